// File: rtl/osd_dii_ring_stage.sv
// osd_dii_ring_stage
//   Ring router stage between the host-interface DII ports and the debug ring.
//   Ring traffic is steered by its header word to the local port or onward
//   along the ring. Local traffic is merged onto the ring with packet-atomic
//   round-robin arbitration against the forwarded traffic. Both outputs are
//   single-entry registers, so input ready depends combinationally on output
//   ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ID (param)          ring address of this stage
//   ring_in_*_i/o       upstream ring (slave):  data, first, last, valid / ready
//   ring_out_*_o/i      downstream ring (master): data, first, last, valid / ready
//   local_in_*_i/o      from host interface (slave)
//   local_out_*_o/i     to host interface (master)
module osd_dii_ring_stage #(
    parameter logic [15:0] ID = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] ring_in_data_i,
    input  logic        ring_in_first_i,
    input  logic        ring_in_last_i,
    input  logic        ring_in_valid_i,
    output logic        ring_in_ready_o,

    output logic [15:0] ring_out_data_o,
    output logic        ring_out_first_o,
    output logic        ring_out_last_o,
    output logic        ring_out_valid_o,
    input  logic        ring_out_ready_i,

    input  logic [15:0] local_in_data_i,
    input  logic        local_in_first_i,
    input  logic        local_in_last_i,
    input  logic        local_in_valid_i,
    output logic        local_in_ready_o,

    output logic [15:0] local_out_data_o,
    output logic        local_out_first_o,
    output logic        local_out_last_o,
    output logic        local_out_valid_o,
    input  logic        local_out_ready_i
);

    typedef enum logic [1:0] {R_IDLE, R_LOCAL, R_FWD} rstate_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_FWD, OWN_LOC} owner_e;

    rstate_e     r_state_q, r_state_d;
    owner_e      owner_q, owner_d, grant;
    logic        last_grant_q, last_grant_d;  // 1 = local won last, 0 = ring won last

    logic [15:0] ro_data_q, ro_data_d;
    logic        ro_first_q, ro_first_d, ro_last_q, ro_last_d, ro_vld_q, ro_vld_d;
    logic [15:0] lo_data_q, lo_data_d;
    logic        lo_first_q, lo_first_d, lo_last_q, lo_last_d, lo_vld_q, lo_vld_d;

    logic        route_local, ro_free, lo_free, fwd_req, fwd_ready;
    logic        ring_xfer, fwd_xfer, lout_load, lin_xfer;

    // In R_IDLE the current flit is a header whatever its first flag says,
    // so the route is decided from its data on the same cycle (no bubble).
    assign route_local = (r_state_q == R_IDLE) ? (ring_in_data_i == ID)
                                               : (r_state_q == R_LOCAL);
    assign ro_free     = !ro_vld_q | ring_out_ready_i;
    assign lo_free     = !lo_vld_q | local_out_ready_i;
    assign fwd_req     = ring_in_valid_i & !route_local;

    // Grant is combinational so a winner transfers in the cycle it wins.
    always_comb begin
        grant = owner_q;
        if (owner_q == OWN_NONE) begin
            if (fwd_req && local_in_valid_i)
                grant = last_grant_q ? OWN_FWD : OWN_LOC;
            else if (fwd_req)
                grant = OWN_FWD;
            else if (local_in_valid_i)
                grant = OWN_LOC;
            else
                grant = OWN_NONE;
        end
    end

    // A source only loses ready when the other one holds the grant; with
    // no requester both report ready so an idle stage looks empty.
    assign fwd_ready        = ro_free & (grant != OWN_LOC);
    assign local_in_ready_o = ro_free & (grant != OWN_FWD);
    // Head-of-line blocking: a stalled selected path stalls the whole ring input.
    assign ring_in_ready_o  = route_local ? lo_free : fwd_ready;

    assign ring_xfer = ring_in_valid_i & ring_in_ready_o;
    assign fwd_xfer  = ring_xfer & !route_local;
    assign lout_load = ring_xfer & route_local;
    assign lin_xfer  = local_in_valid_i & local_in_ready_o;

    always_comb begin
        r_state_d    = r_state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;

        // Demux: latch the route on a multi-flit header, release on last.
        case (r_state_q)
            R_IDLE: begin
                if (ring_xfer && !ring_in_last_i)
                    r_state_d = route_local ? R_LOCAL : R_FWD;
            end
            default: begin
                if (ring_xfer && ring_in_last_i)
                    r_state_d = R_IDLE;
            end
        endcase

        // Arbiter: hold ownership for the whole packet.
        if (grant == OWN_FWD && fwd_xfer) begin
            owner_d = ring_in_last_i ? OWN_NONE : OWN_FWD;
            if (ring_in_last_i) last_grant_d = 1'b0;
        end else if (grant == OWN_LOC && lin_xfer) begin
            owner_d = local_in_last_i ? OWN_NONE : OWN_LOC;
            if (local_in_last_i) last_grant_d = 1'b1;
        end
    end

    // Output registers: load on accept, otherwise clear valid when drained.
    always_comb begin
        ro_data_d  = ro_data_q;
        ro_first_d = ro_first_q;
        ro_last_d  = ro_last_q;
        ro_vld_d   = ro_vld_q & !ring_out_ready_i;
        if (fwd_xfer) begin
            ro_data_d  = ring_in_data_i;
            ro_first_d = ring_in_first_i;
            ro_last_d  = ring_in_last_i;
            ro_vld_d   = 1'b1;
        end else if (lin_xfer) begin
            ro_data_d  = local_in_data_i;
            ro_first_d = local_in_first_i;
            ro_last_d  = local_in_last_i;
            ro_vld_d   = 1'b1;
        end

        lo_data_d  = lo_data_q;
        lo_first_d = lo_first_q;
        lo_last_d  = lo_last_q;
        lo_vld_d   = lo_vld_q & !local_out_ready_i;
        if (lout_load) begin
            lo_data_d  = ring_in_data_i;
            lo_first_d = ring_in_first_i;
            lo_last_d  = ring_in_last_i;
            lo_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            owner_q      <= OWN_NONE;
            last_grant_q <= 1'b1;
            ro_data_q    <= '0;
            ro_first_q   <= 1'b0;
            ro_last_q    <= 1'b0;
            ro_vld_q     <= 1'b0;
            lo_data_q    <= '0;
            lo_first_q   <= 1'b0;
            lo_last_q    <= 1'b0;
            lo_vld_q     <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ro_data_q    <= ro_data_d;
            ro_first_q   <= ro_first_d;
            ro_last_q    <= ro_last_d;
            ro_vld_q     <= ro_vld_d;
            lo_data_q    <= lo_data_d;
            lo_first_q   <= lo_first_d;
            lo_last_q    <= lo_last_d;
            lo_vld_q     <= lo_vld_d;
        end
    end

    assign ring_out_data_o   = ro_data_q;
    assign ring_out_first_o  = ro_first_q;
    assign ring_out_last_o   = ro_last_q;
    assign ring_out_valid_o  = ro_vld_q;
    assign local_out_data_o  = lo_data_q;
    assign local_out_first_o = lo_first_q;
    assign local_out_last_o  = lo_last_q;
    assign local_out_valid_o = lo_vld_q;

endmodule
